// File: rtl/nw_pkg.sv
// nw_pkg: definitions shared by the Needleman-Wunsch loader and grid.
//   nw_loader_state_t : loader FSM state encoding
//   LENGTH/CWIDTH/SWIDTH : default string length, char width, score width
//   MATCH/INDEL/MISMATCH : default scoring constants of the grid
package nw_pkg;

  localparam int LENGTH   = 10;
  localparam int CWIDTH   = 2;
  localparam int SWIDTH   = 16;
  localparam int MATCH    = 1;
  localparam int INDEL    = -1;
  localparam int MISMATCH = -1;

  typedef enum logic [2:0] {
    LOAD_S1 = 3'd0,
    LOAD_S2 = 3'd1,
    FIRE    = 3'd2,
    WAIT    = 3'd3,
    RESULT  = 3'd4
  } nw_loader_state_t;

endpackage

// File: rtl/nw_stream_loader.sv
// nw_stream_loader: serial-to-parallel front end for the Needleman-Wunsch grid.
// Packs a character stream (s1 first, then s2) into grid_s1/grid_s2, pulses
// grid_valid for one cycle, waits for a rising edge of grid_done, captures
// grid_score and offers it on a valid/ready result port. One alignment at a
// time.
//
// Optional build macro NW_LOADER_TIMEOUT_EN adds a watchdog that ends WAIT
// after TIMEOUT cycles with res_score = 0 and res_timeout = 1. Without it,
// res_timeout is tied to 0 and WAIT waits indefinitely.
//
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid/in_ready/in_char     : character stream input
//   grid_s1/grid_s2/grid_valid    : packed strings and start pulse to the grid
//   grid_score/grid_done          : grid result (done may be pulse or level)
//   res_valid/res_ready/res_score/res_timeout : result output
module nw_stream_loader #(
  parameter int LENGTH  = nw_pkg::LENGTH,
  parameter int CWIDTH  = nw_pkg::CWIDTH,
  parameter int SWIDTH  = nw_pkg::SWIDTH,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CWIDTH-1:0]        in_char,
  output logic [LENGTH*CWIDTH-1:0] grid_s1,
  output logic [LENGTH*CWIDTH-1:0] grid_s2,
  output logic                     grid_valid,
  input  logic signed [SWIDTH-1:0] grid_score,
  input  logic                     grid_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [SWIDTH-1:0] res_score,
  output logic                     res_timeout
);

  import nw_pkg::*;

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LENGTH - 1);

  nw_loader_state_t          state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [LENGTH*CWIDTH-1:0]  s1_q, s1_d;
  logic [LENGTH*CWIDTH-1:0]  s2_q, s2_d;
  logic signed [SWIDTH-1:0]  score_q, score_d;
  logic                      done_q;
  logic                      accept;
  logic                      done_rise;

`ifdef NW_LOADER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] wd_q, wd_d;
  logic            tout_q, tout_d;
  logic            wd_hit;

  // Counter is cleared while in FIRE so it reads 0 on the first WAIT cycle.
  always_comb begin
    wd_d = wd_q;
    if (state_q == FIRE) begin
      wd_d = '0;
    end else if (state_q == WAIT) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_hit = (state_q == WAIT) && (wd_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      tout_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      tout_q <= tout_d;
    end
  end

  assign res_timeout = tout_q;
`else
  // No watchdog: TIMEOUT has no effect, the expression is constant 0.
  assign res_timeout = (TIMEOUT < 0);
`endif

  assign in_ready   = (state_q == LOAD_S1) || (state_q == LOAD_S2);
  assign grid_valid = (state_q == FIRE);
  assign res_valid  = (state_q == RESULT);
  assign grid_s1    = s1_q;
  assign grid_s2    = s2_q;
  assign res_score  = score_q;

  assign accept    = in_valid && in_ready;
  // Edge detect, so a done level left over from the previous run is ignored.
  assign done_rise = grid_done && !done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    score_d = score_q;
`ifdef NW_LOADER_TIMEOUT_EN
    tout_d  = tout_q;
`endif
    case (state_q)
      LOAD_S1: begin
        if (accept) begin
          s1_d[idx_q*CWIDTH +: CWIDTH] = in_char;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = LOAD_S2;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOAD_S2: begin
        if (accept) begin
          s2_d[idx_q*CWIDTH +: CWIDTH] = in_char;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = FIRE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FIRE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A done edge takes priority over a watchdog expiry in the same cycle.
        if (done_rise) begin
          score_d = grid_score;
`ifdef NW_LOADER_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
          state_d = RESULT;
        end
`ifdef NW_LOADER_TIMEOUT_EN
        else if (wd_hit) begin
          score_d = '0;
          tout_d  = 1'b1;
          state_d = RESULT;
        end
`endif
      end
      RESULT: begin
        if (res_ready) begin
          state_d = LOAD_S1;
        end
      end
      default: begin
        state_d = LOAD_S1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_S1;
      idx_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      score_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      score_q <= score_d;
      done_q  <= grid_done;
    end
  end

endmodule

// File: tb/tb_nw_stream_loader.sv
// Testbench for nw_stream_loader with LENGTH=4, CWIDTH=2, TIMEOUT=16.
// Randomized strings, input gaps, grid latency, scores and result
// backpressure, checked against packing/timing expectations derived from
// the loader's behaviour at the transaction level.
module tb_nw_stream_loader;

  localparam int LENGTH  = 4;
  localparam int CWIDTH  = 2;
  localparam int SWIDTH  = 16;
  localparam int TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [CWIDTH-1:0]        in_char;
  logic [LENGTH*CWIDTH-1:0] grid_s1;
  logic [LENGTH*CWIDTH-1:0] grid_s2;
  logic                     grid_valid;
  logic signed [SWIDTH-1:0] grid_score;
  logic                     grid_done;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [SWIDTH-1:0] res_score;
  logic                     res_timeout;

  int n_chk  = 0;
  int n_pass = 0;
  int chars[2*LENGTH];

  nw_stream_loader #(
    .LENGTH (LENGTH),
    .CWIDTH (CWIDTH),
    .SWIDTH (SWIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .grid_s1    (grid_s1),
    .grid_s2    (grid_s2),
    .grid_valid (grid_valid),
    .grid_score (grid_score),
    .grid_done  (grid_done),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_score  (res_score),
    .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed value of string s (0 = s1, 1 = s2): character i weighted by 4**i.
  function automatic int packed_val(input int s);
    int v = 0;
    for (int i = 0; i < LENGTH; i++) v += chars[s*LENGTH + i] * (1 << (CWIDTH*i));
    return v;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_s1"}, grid_s1, 0);
    chk({tag, "_s2"}, grid_s2, 0);
    chk({tag, "_gv"}, grid_valid, 0);
    chk({tag, "_rv"}, res_valid, 0);
    chk({tag, "_rs"}, res_score, 0);
    chk({tag, "_rt"}, res_timeout, 0);
    chk({tag, "_ir"}, in_ready, 1);
  endtask

  // Stream chars[0..n-1]; optional random in_valid gaps.
  task automatic stream(input int n, input bit gaps);
    int  guard;
    bit  take;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      take  = 0;
      while (!take) begin
        in_char  = CWIDTH'(chars[i]);
        in_valid = !gaps || ($urandom_range(0, 2) != 0);
        take     = in_valid && in_ready;
        tick();
        guard++;
        if (guard > 20) begin
          chk("load_stall", 0, 1);
          summary();
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_align(input bit fixed, input bit gaps, input bit stale,
                           input int lat, input logic signed [SWIDTH-1:0] score,
                           input int bp);
    int e1, e2;
    if (!fixed) for (int i = 0; i < 2*LENGTH; i++) chars[i] = $urandom_range(0, 3);
    e1 = packed_val(0);
    e2 = packed_val(1);
    res_ready = 1'b0;
    grid_done = stale;
    stream(2*LENGTH, gaps);
    // One cycle after the last accept: start pulse with both strings packed.
    chk("fire_pulse", grid_valid, 1);
    chk("fire_s1", grid_s1, e1);
    chk("fire_s2", grid_s2, e2);
    chk("fire_in_ready", in_ready, 0);
    if (fixed) begin
      chk("basic_s1", grid_s1, 64'hE4);
      chk("basic_s2", grid_s2, 64'h1B);
    end
    tick();
    chk("fire_once", grid_valid, 0);
    if (stale) begin
      repeat (3) begin
        tick();
        chk("stale_hold", res_valid, 0);
      end
      grid_done = 1'b0;
      tick();
      chk("stale_low", res_valid, 0);
    end
    repeat (lat) tick();
    chk("no_early_res", res_valid, 0);
    grid_done  = 1'b1;
    grid_score = score;
    tick();
    chk("res_valid", res_valid, 1);
    chk("res_score", res_score, score);
    chk("res_timeout", res_timeout, 0);
    chk("res_s1_stable", grid_s1, e1);
    grid_score = SWIDTH'($urandom);
    grid_done  = $urandom_range(0, 1) != 0;
    for (int k = 0; k < bp; k++) begin
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_score", res_score, score);
      chk("bp_in_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_res_valid", res_valid, 0);
  endtask

  initial begin
    int w;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_char    = '0;
    grid_score = '0;
    grid_done  = 1'b0;
    res_ready  = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Basic load and score capture with long backpressure.
    chars = '{0, 1, 2, 3, 3, 2, 1, 0};
    run_align(1'b1, 1'b0, 1'b0, 4, -16'sd3, 10);

    // Randomized runs: gaps, stale done levels, latencies, scores.
    for (int r = 0; r < 8; r++) begin
      run_align(1'b0, r[0], r[1] | ($urandom_range(0, 1) != 0),
                $urandom_range(0, 6), SWIDTH'($urandom), $urandom_range(0, 4));
    end

    // Reset in the middle of loading s2.
    grid_done = 1'b0;
    for (int i = 0; i < 2*LENGTH; i++) chars[i] = $urandom_range(0, 3);
    stream(LENGTH + 3, 1'b0);
    rst_n = 1'b0;
    #2;
    check_idle("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");
    run_align(1'b0, 1'b1, 1'b0, 2, -16'sd77, 2);

    // Grid that never finishes.
    grid_done = 1'b0;
    for (int i = 0; i < 2*LENGTH; i++) chars[i] = $urandom_range(0, 3);
    stream(2*LENGTH, 1'b0);
    tick();
`ifdef NW_LOADER_TIMEOUT_EN
    // Now in the first WAIT cycle; result due exactly TIMEOUT cycles later.
    w = 0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      if (res_valid) w++;
    end
    chk("wd_early", w, 0);
    tick();
    chk("wd_valid", res_valid, 1);
    chk("wd_timeout", res_timeout, 1);
    chk("wd_score", res_score, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("wd_post_in_ready", in_ready, 1);
`else
    w = 0;
    for (int k = 0; k < 3*TIMEOUT; k++) begin
      tick();
      if (res_valid) w++;
    end
    chk("no_wd_res_valid", w, 0);
    chk("no_wd_timeout", res_timeout, 0);
`endif
    summary();
  end

endmodule

// File: doc/nw_stream_loader.md
# nw_stream_loader

Front-end stage for the Needleman-Wunsch scoring grid. Accepts two strings as a serial valid/ready character stream and packs them into the grid's parallel `s1`/`s2` buses. It then issues a one-cycle start pulse, waits for the grid's done, captures the score, and presents it on a valid/ready result port. Exactly one alignment is in flight at a time.

## Interface
- `LENGTH`, 10: characters per string; must be ≥1.
- `CWIDTH`, 2: bits per character.
- `SWIDTH`, 16: bits per score.
- `TIMEOUT`, 1024: watchdog limit in cycles; used only with `NW_LOADER_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: `in_char` is valid.
- `in_ready`, out, 1: the loader accepts a character this cycle.
- `in_char`, in, CWIDTH: character; s1 characters come first, then s2 characters.
- `grid_s1`, out, LENGTH*CWIDTH: packed s1 to the grid.
- `grid_s2`, out, LENGTH*CWIDTH: packed s2 to the grid.
- `grid_valid`, out, 1: one-cycle start pulse to the grid.
- `grid_score`, in, SWIDTH (signed): score from the grid.
- `grid_done`, in, 1: done from the grid (pulse or level).
- `res_valid`, out, 1: result is valid.
- `res_ready`, in, 1: consumer accepts the result.
- `res_score`, out, SWIDTH (signed): captured score.
- `res_timeout`, out, 1: result was produced by the watchdog; meaningful only while `res_valid` is high.

## Operation
- The state machine has five states: `LOAD_S1`, `LOAD_S2`, `FIRE`, `WAIT`, `RESULT`.
- `in_ready` = 1 only in `LOAD_S1` and `LOAD_S2`. A character is accepted on a cycle where `in_valid && in_ready`.
- Index counter `idx`, width `$clog2(LENGTH)` (minimum 1):
  - An accepted character is written to slice `[idx*CWIDTH +: CWIDTH]` of the current string. Character 0 lands in the LSBs.
  - `idx` increments on each accept. At `LENGTH-1`, `idx` wraps to 0 and the state advances: `LOAD_S1`→`LOAD_S2`, `LOAD_S2`→`FIRE`.
  - When `LENGTH`=1, each load state accepts exactly one character.
- `FIRE`: `grid_valid` = 1 for exactly one cycle, then the state moves to `WAIT`.
- `WAIT`: a registered copy `done_q` of `grid_done` is kept, with reset value 0. On the first cycle where `grid_done && !done_q`:
  - `grid_score` is latched into `res_score`.
  - `res_timeout` is set to 0.
  - The state moves to `RESULT`.
  - Because capture is edge-based, a level `grid_done` left high from the previous run is not captured as a new result. The grid must drop `grid_done` before asserting it for the new run.
- `RESULT`: `res_valid` = 1, and `res_score`/`res_timeout` are held stable until `res_valid && res_ready`. On that handshake the state returns to `LOAD_S1`.
- `grid_s1`/`grid_s2` change only on accepted characters, so they are stable from `FIRE` through `RESULT`.
- Reset, including reset asserted mid-operation: state = `LOAD_S1`; `idx`, `grid_s1`, `grid_s2`, `res_score`, `done_q` = 0; outputs `grid_valid` = 0, `res_valid` = 0, `res_timeout` = 0. Any partial load is discarded.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from input to output.
- Let the last s2 character be accepted at cycle N:
  - `grid_valid` is high in cycle N+1.
  - `WAIT` begins at N+2.
- Let the rising edge of `grid_done` be sampled at cycle M: `res_valid` is high from cycle M+1.
- `in_ready` rises the cycle after the result handshake.
- Minimum throughput is one alignment per 2*LENGTH + 3 + grid latency cycles.
- `grid_done` edges outside `WAIT` are ignored. `done_q` still tracks `grid_done` in every state.

## Configuration
- `NW_LOADER_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to `WAIT` and increments each cycle in `WAIT`.
  - When it reaches `TIMEOUT-1` with no done edge, the state moves to `RESULT` with `res_score` = 0 and `res_timeout` = 1.
  - If a done edge arrives in that same cycle, the done edge wins and `res_timeout` = 0.
- Not defined: no counter is built, `res_timeout` is constant 0, and `WAIT` waits indefinitely.

## Structure
- Package `nw_pkg` holds:
  - The state enum `nw_loader_state_t`.
  - Defaults shared with the grid: `LENGTH`, `CWIDTH`, `SWIDTH`, `MATCH`, `INDEL`, `MISMATCH`.
- No sub-module. The optional watchdog lives inline under the macro.

## Test plan
All scenarios use LENGTH=4, CWIDTH=2.
- **Basic load.** Stream s1 = 0,1,2,3 then s2 = 3,2,1,0 with `in_valid` held high.
  - Expect `grid_s1`=8'hE4 and `grid_s2`=8'h1B.
  - Expect `grid_valid` high for exactly one cycle, one cycle after the 8th accept.
- **Score capture.** The grid model pulses `grid_done` 5 cycles after `grid_valid` with `grid_score`=-3. Expect `res_valid`=1 and `res_score`=-3 on the next cycle.
- **Result backpressure.** Hold `res_ready`=0 for 10 cycles.
  - Expect `res_valid` and `res_score` stable, and `in_ready`=0 throughout.
  - Release `res_ready`; expect `in_ready`=1 on the following cycle.
- **Input gaps and stale done.** Insert random `in_valid` gaps, and hold `grid_done` high from the previous run through `FIRE`.
  - Expect packing unchanged.
  - Expect no capture until `grid_done` falls and rises again.
- **Reset mid-operation.** Assert `rst_n`=0 after 3 s2 characters have been accepted.
  - Expect all outputs 0 and `in_ready`=1 after release.
  - A fresh 8-character stream must load correctly.
- **Watchdog.** With `NW_LOADER_TIMEOUT_EN` defined and TIMEOUT=16, `grid_done` is never asserted.
  - Expect `res_valid`=1, `res_timeout`=1, `res_score`=0 exactly 16 cycles after `WAIT` entry.
  - Without the macro, `res_valid` must stay 0.
